i2c_arbiter: RTL and testbench
==============================

# i2c_arbiter

Shares one `i2c_master` EEPROM transaction engine between `NREQ` independent requesters, such as a config loader and a host-command path. It grants requesters round-robin and latches the granted request onto the master's command inputs, holding them stable. It issues a one-cycle `start`, waits for `byte_done` or `error` (or a watchdog timeout), then returns read data and status to the granted requester. It sits between the requester logic and the `i2c_master` instance; the SCL/SDA pins stay on the master.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2 to 4.
- `TIMEOUT_CYCLES`, 200000: watchdog limit in `clk` cycles from `m_start` to completion.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input NREQ: requester i has a transaction pending.
- `req_ready` output NREQ: one-cycle accept pulse to requester i.
- `req_rw` input NREQ: 1 = read, 0 = write, per requester.
- `req_addr` input 7*NREQ: 7-bit device address, slice i.
- `req_byte_addr` input 8*NREQ: 8-bit byte address, slice i.
- `req_wdata` input 8*NREQ: write data, slice i.
- `resp_valid` output NREQ: one-cycle completion pulse to requester i.
- `resp_rdata` output 8: read data; valid with any `resp_valid` bit.
- `resp_error` output 1: NACK or timeout; valid with `resp_valid`.
- `m_start` output 1: to master `start`.
- `m_rw` output 1: to master `rw`.
- `m_addr` output 7: to master `addr`.
- `m_byte_addr` output 8: to master `byte_address`.
- `m_din` output 8: to master `din`.
- `m_dout` input 8: from master `dout`.
- `m_byte_done` input 1: from master; level that may stay high for many cycles.
- `m_error` input 1: from master.
- `m_rst` output 1: OR'd with `rst` into master reset; pulses on timeout.
- `busy` output 1: high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP, COOLDOWN.

- **IDLE:** if any `req_valid`, grant the first set bit searching from `last_grant+1` modulo NREQ.
  - Pulse `req_ready[g]` and latch rw/addr/byte_addr/wdata into `m_*`.
  - Set `last_grant <= g`, then go to ISSUE.
- **ISSUE:** `m_start=1` for exactly one cycle; clear the watchdog; go to WAIT.
- **WAIT:** the watchdog increments every cycle.
  - If `m_error` is high: set error, go to RESP. `m_error` wins if both inputs are high in the same cycle.
  - Else if `m_byte_done` is high: capture `m_dout` into `resp_rdata` (writes also capture it; requesters ignore it), clear error, go to RESP.
  - Else if the watchdog equals `TIMEOUT_CYCLES-1`: set error, pulse `m_rst` for one cycle, go to RESP.
- **RESP:** pulse `resp_valid[g]` for one cycle; go to COOLDOWN.
- **COOLDOWN:** stay until `m_byte_done==0` and `m_error==0` are sampled together, then go to IDLE. This prevents one long DONE level from completing two transactions.
- **Output stability:** `m_rw`, `m_addr`, `m_byte_addr` and `m_din` are held constant from ISSUE through COOLDOWN, because the master samples `rw` throughout the transaction.
- **Requester handshake:** a requester keeps its fields stable while `req_valid` is high until it sees `req_ready`. It may deassert `req_valid` without a grant; nothing is then latched for it.
- **Errors are not retried:** an errored transaction goes straight back to its requester.

## Timing
- **Reset values:** all outputs 0, `m_*` fields 0, state IDLE, `last_grant = NREQ-1` (so requester 0 wins first).
- **Accept to start:** `req_ready` in cycle N, `m_start` in cycle N+1.
- **Completion to response:** `m_byte_done` or `m_error` first seen high in cycle M gives `resp_valid` in cycle M+1.
- **Minimum gap between grants:** 3 cycles, from the RESP cycle through at least one COOLDOWN cycle.
- **Reset mid-transaction:** immediate return to IDLE with all outputs 0. No `resp_valid` is issued for the aborted request. The master shares `rst`, so it resets with the arbiter.
- **Timeout boundary:** at exactly `TIMEOUT_CYCLES` WAIT cycles the transaction is a timeout, even if `m_byte_done` arrives in the following cycle.

## Structure
- **Shared package `i2c_pkg`:** state encoding localparams, `I2C_ADDR_W=7`, `I2C_DATA_W=8`.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are the request vector and the last grant; outputs are a one-hot grant and its index.
- The watchdog counter width is `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- **Single write:** req0 write to addr 0x50, byte 0x10, data 0xA5; the model raises `m_byte_done` 5 cycles after `m_start` and holds it 100 cycles. Expect `resp_valid[0]` with `resp_error=0`, exactly one response, and `m_*` stable throughout.
- **Read:** req1 read from 0x50, byte 0x20; the model returns `m_dout=0x3C`. Expect `resp_rdata=0x3C` and `resp_valid[1]` one cycle after `m_byte_done` rises.
- **Contention:** req0 and req1 held valid continuously for 4 transactions. Expect grants in order 0, 1, 0, 1, and never two `m_start` pulses without an intervening COOLDOWN exit.
- **NACK:** the model pulses `m_error` in WAIT. Expect `resp_error=1`, no `m_rst` pulse, and return to IDLE.
- **Timeout:** TIMEOUT_CYCLES=50 and the model never completes. Expect `m_rst` high for 1 cycle at WAIT cycle 50, then `resp_error=1`.
- **Async reset:** assert `rst` mid-WAIT between clock edges. Expect all outputs 0 immediately, no `resp_valid`, and a fresh grant to requester 0 afterwards.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and FSM state encoding for the I2C master arbiter.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_ISSUE_ENC    = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC     = 3'd2;
    localparam logic [2:0] ST_RESP_ENC     = 3'd3;
    localparam logic [2:0] ST_COOLDOWN_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_ISSUE    = ST_ISSUE_ENC,
        ST_WAIT     = ST_WAIT_ENC,
        ST_RESP     = ST_RESP_ENC,
        ST_COOLDOWN = ST_COOLDOWN_ENC
    } state_t;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic            any_o,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o
);

    logic [IDXW-1:0] cand;
    logic            found;

    // Walk candidates last+1 .. last+NREQ so the previous winner is checked last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(last_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master transaction engine between NREQ requesters.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [7*NREQ-1:0]      req_addr,
    input  logic [8*NREQ-1:0]      req_byte_addr,
    input  logic [8*NREQ-1:0]      req_wdata,
    output logic [NREQ-1:0]        resp_valid,
    output logic [I2C_DATA_W-1:0]  resp_rdata,
    output logic                   resp_error,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [I2C_ADDR_W-1:0]  m_addr,
    output logic [I2C_DATA_W-1:0]  m_byte_addr,
    output logic [I2C_DATA_W-1:0]  m_din,
    input  logic [I2C_DATA_W-1:0]  m_dout,
    input  logic                   m_byte_done,
    input  logic                   m_error,
    output logic                   m_rst,
    output logic                   busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q,      state_d;
    logic [IDXW-1:0]        last_grant_q, last_grant_d;
    logic [NREQ-1:0]        grant_oh_q,   grant_oh_d;
    logic                   rw_q,         rw_d;
    logic [I2C_ADDR_W-1:0]  addr_q,       addr_d;
    logic [I2C_DATA_W-1:0]  byte_addr_q,  byte_addr_d;
    logic [I2C_DATA_W-1:0]  din_q,        din_d;
    logic [I2C_DATA_W-1:0]  rdata_q,      rdata_d;
    logic                   error_q,      error_d;
    logic [WD_W-1:0]        wd_q,         wd_d;

    logic                   pick_any;
    logic [NREQ-1:0]        pick_oh;
    logic [IDXW-1:0]        pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .last_i  (last_grant_q),
        .any_o   (pick_any),
        .grant_o (pick_oh),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDXW'(NREQ - 1);
            grant_oh_q   <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            byte_addr_q  <= '0;
            din_q        <= '0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_oh_q   <= grant_oh_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            byte_addr_q  <= byte_addr_d;
            din_q        <= din_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
            wd_q         <= wd_d;
        end
    end

    // Command fields only change on a grant, so the master sees them stable for the whole transaction.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_oh_d   = grant_oh_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        byte_addr_d  = byte_addr_q;
        din_d        = din_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        wd_d         = wd_q;
        req_ready    = '0;
        resp_valid   = '0;
        m_start      = 1'b0;
        m_rst        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready    = pick_oh;
                    grant_oh_d   = pick_oh;
                    last_grant_d = pick_idx;
                    rw_d         = req_rw[pick_idx];
                    addr_d       = req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
                    byte_addr_d  = req_byte_addr[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                    din_d        = req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_start = 1'b1;
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (m_error) begin
                    error_d = 1'b1;
                    state_d = ST_RESP;
                end else if (m_byte_done) begin
                    rdata_d = m_dout;
                    error_d = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    m_rst   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = grant_oh_q;
                state_d    = ST_COOLDOWN;
            end
            // A long DONE level must drop before the next grant, or it would complete two transactions.
            ST_COOLDOWN: begin
                if (!m_byte_done && !m_error) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_rw        = rw_q;
    assign m_addr      = addr_q;
    assign m_byte_addr = byte_addr_q;
    assign m_din       = din_q;
    assign resp_rdata  = rdata_q;
    assign resp_error  = error_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed testbench for i2c_arbiter with a cycle-scripted i2c_master stand-in.
module tb_i2c_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [1:0]  reqRw;
    logic [13:0] reqAddr;
    logic [15:0] reqByteAddr;
    logic [15:0] reqWdata;
    logic [1:0]  respValid;
    logic [7:0]  respRdata;
    logic        respError;
    logic        mStart;
    logic        mRw;
    logic [6:0]  mAddr;
    logic [7:0]  mByteAddr;
    logic [7:0]  mDin;
    logic [7:0]  mDout;
    logic        mByteDone;
    logic        mError;
    logic        mRst;
    logic        busy;

    int passCount;
    int checkCount;

    logic [1:0]  obsRespVec;
    logic [7:0]  obsRespData;
    logic        obsRespErr;
    int          obsRespCnt;
    int          obsRespCycle;
    int          obsRstCnt;
    int          obsRstCycle;
    int          obsStartCnt;
    int          obsUnstable;
    logic        obsFinished;
    logic [23:0] snapCmd;
    int          quietCount;

    i2c_arbiter #(
        .NREQ           (2),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (reqValid),
        .req_ready     (reqReady),
        .req_rw        (reqRw),
        .req_addr      (reqAddr),
        .req_byte_addr (reqByteAddr),
        .req_wdata     (reqWdata),
        .resp_valid    (respValid),
        .resp_rdata    (respRdata),
        .resp_error    (respError),
        .m_start       (mStart),
        .m_rw          (mRw),
        .m_addr        (mAddr),
        .m_byte_addr   (mByteAddr),
        .m_din         (mDin),
        .m_dout        (mDout),
        .m_byte_done   (mByteDone),
        .m_error       (mError),
        .m_rst         (mRst),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic rw, input logic [6:0] addr,
                                 input logic [7:0] byteAddr, input logic [7:0] wdata);
        reqRw[idx]             = rw;
        reqAddr[idx*7 +: 7]    = addr;
        reqByteAddr[idx*8 +: 8] = byteAddr;
        reqWdata[idx*8 +: 8]   = wdata;
        reqValid[idx]          = 1'b1;
    endtask

    // Called in the ISSUE cycle; cycle c counts from m_start. Completion is held high for
    // cycles delay .. delay+hold-1, then the task runs until the arbiter is idle again.
    task automatic masterTxn(input int delay, input int hold, input logic useErr, input logic [7:0] dout);
        snapCmd      = {mRw, mAddr, mByteAddr, mDin};
        obsRespVec   = '0;
        obsRespData  = '0;
        obsRespErr   = 1'b0;
        obsRespCnt   = 0;
        obsRespCycle = 0;
        obsRstCnt    = 0;
        obsRstCycle  = 0;
        obsStartCnt  = 0;
        obsUnstable  = 0;
        obsFinished  = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c >= delay && c < delay + hold) begin
                mByteDone = !useErr;
                mError    = useErr;
                mDout     = dout;
            end else begin
                mByteDone = 1'b0;
                mError    = 1'b0;
            end
            #1;
            if (respValid != 2'b00) begin
                obsRespCnt++;
                if (obsRespCnt == 1) begin
                    obsRespCycle = c;
                    obsRespVec   = respValid;
                    obsRespData  = respRdata;
                    obsRespErr   = respError;
                end
            end
            if (mRst) begin
                obsRstCnt++;
                obsRstCycle = c;
            end
            if (mStart) obsStartCnt++;
            if (busy && {mRw, mAddr, mByteAddr, mDin} != snapCmd) obsUnstable++;
            if (!busy && obsRespCnt > 0) begin
                obsFinished = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] stopped");
    end

    initial begin
        passCount   = 0;
        checkCount  = 0;
        rst         = 1'b1;
        reqValid    = '0;
        reqRw       = '0;
        reqAddr     = '0;
        reqByteAddr = '0;
        reqWdata    = '0;
        mDout       = '0;
        mByteDone   = 1'b0;
        mError      = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", reqReady, 0);
        checkOutput("rst_cmd", {mStart, mRw, mAddr, mByteAddr, mDin, mRst}, 0);
        checkOutput("rst_resp", {respValid, respRdata, respError}, 0);
        rst = 1'b0;

        // Single write from requester 0, DONE held for 100 cycles.
        @(negedge clk);
        applyStimulus(0, 1'b0, 7'h50, 8'h10, 8'hA5);
        #1 checkOutput("wr_ready", reqReady, 2'b01);
        @(negedge clk);
        reqValid = 2'b00;
        #1;
        checkOutput("wr_start", mStart, 1);
        checkOutput("wr_cmd", {mRw, mAddr, mByteAddr, mDin}, {1'b0, 7'h50, 8'h10, 8'hA5});
        checkOutput("wr_busy", busy, 1);
        masterTxn(5, 100, 1'b0, 8'h77);
        checkOutput("wr_resp_vec", obsRespVec, 2'b01);
        checkOutput("wr_resp_err", obsRespErr, 0);
        checkOutput("wr_resp_data", obsRespData, 8'h77);
        checkOutput("wr_resp_cycle", obsRespCycle, 6);
        checkOutput("wr_resp_count", obsRespCnt, 1);
        checkOutput("wr_stable", obsUnstable, 0);
        checkOutput("wr_extra_start", obsStartCnt, 0);
        checkOutput("wr_no_mrst", obsRstCnt, 0);
        checkOutput("wr_finished", obsFinished, 1);

        // Read from requester 1.
        applyStimulus(1, 1'b1, 7'h50, 8'h20, 8'h00);
        #1 checkOutput("rd_ready", reqReady, 2'b10);
        @(negedge clk);
        reqValid = 2'b00;
        #1;
        checkOutput("rd_start", mStart, 1);
        checkOutput("rd_cmd", {mRw, mAddr, mByteAddr}, {1'b1, 7'h50, 8'h20});
        masterTxn(4, 3, 1'b0, 8'h3C);
        checkOutput("rd_resp_vec", obsRespVec, 2'b10);
        checkOutput("rd_resp_data", obsRespData, 8'h3C);
        checkOutput("rd_resp_err", obsRespErr, 0);
        checkOutput("rd_resp_cycle", obsRespCycle, 5);
        checkOutput("rd_resp_count", obsRespCnt, 1);

        // Both requesters valid continuously for four transactions.
        applyStimulus(0, 1'b0, 7'h50, 8'h01, 8'h11);
        applyStimulus(1, 1'b0, 7'h51, 8'h02, 8'h22);
        for (int t = 0; t < 4; t++) begin
            #1;
            for (int w = 0; w < 10 && reqReady == 2'b00; w++) begin
                @(negedge clk);
                #1;
            end
            checkOutput($sformatf("rr_grant%0d", t), reqReady, (t % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            #1;
            checkOutput($sformatf("rr_addr%0d", t), {mStart, mAddr}, (t % 2 == 0) ? {1'b1, 7'h50} : {1'b1, 7'h51});
            masterTxn(3, 2, 1'b0, 8'h00);
            checkOutput($sformatf("rr_resp%0d", t), obsRespVec, (t % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("rr_single_start%0d", t), obsStartCnt, 0);
        end
        reqValid = 2'b00;

        // NACK: one-cycle error pulse from the master.
        @(negedge clk);
        applyStimulus(0, 1'b0, 7'h50, 8'h40, 8'h5A);
        #1 checkOutput("nack_ready", reqReady, 2'b01);
        @(negedge clk);
        reqValid = 2'b00;
        masterTxn(3, 1, 1'b1, 8'h00);
        checkOutput("nack_resp_vec", obsRespVec, 2'b01);
        checkOutput("nack_resp_err", obsRespErr, 1);
        checkOutput("nack_resp_cycle", obsRespCycle, 4);
        checkOutput("nack_no_mrst", obsRstCnt, 0);
        checkOutput("nack_idle", obsFinished, 1);

        // Timeout: DONE first appears the cycle after the watchdog expires.
        applyStimulus(1, 1'b1, 7'h50, 8'h50, 8'h00);
        @(negedge clk);
        reqValid = 2'b00;
        masterTxn(51, 3, 1'b0, 8'hEE);
        checkOutput("to_mrst_count", obsRstCnt, 1);
        checkOutput("to_mrst_cycle", obsRstCycle, 50);
        checkOutput("to_resp_cycle", obsRespCycle, 51);
        checkOutput("to_resp_vec", obsRespVec, 2'b10);
        checkOutput("to_resp_err", obsRespErr, 1);
        checkOutput("to_resp_count", obsRespCnt, 1);

        // Asynchronous reset in the middle of a requester-0 transaction.
        applyStimulus(0, 1'b1, 7'h52, 8'h30, 8'h00);
        #1 checkOutput("ar_ready", reqReady, 2'b01);
        @(negedge clk);
        reqValid = 2'b00;
        #1 checkOutput("ar_start", mStart, 1);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_cmd", {mStart, mRw, mAddr, mByteAddr, mDin, mRst}, 0);
        checkOutput("ar_resp", {respValid, respRdata, respError}, 0);
        quietCount = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (respValid != 2'b00) quietCount++;
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 7'h53, 8'h31, 8'h99);
        applyStimulus(1, 1'b0, 7'h54, 8'h32, 8'h98);
        #1 checkOutput("ar_fresh_grant", reqReady, 2'b01);
        @(negedge clk);
        reqValid = 2'b00;
        #1 checkOutput("ar_fresh_cmd", {mStart, mAddr}, {1'b1, 7'h53});
        masterTxn(2, 1, 1'b0, 8'h00);
        if (respValid != 2'b00) quietCount++;
        checkOutput("ar_no_stale_resp", quietCount, 0);
        checkOutput("ar_fresh_resp", obsRespVec, 2'b01);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
